// File: rtl/usb_irq_pio_in.sv
// usb_irq_pio_in: Avalon-MM input PIO. Each bit is synchronised, edge-detected, latched in a W1C capture register and raises a maskable irq.
// Define USB_IRQ_PIO_DEBOUNCE_EN to add a per-bit debounce filter after the synchroniser.
module usb_irq_pio_in #(
    parameter int WIDTH           = 1,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_CAP  = 2'd3
    } addr_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef USB_IRQ_PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt [WIDTH];
    logic [WIDTH-1:0] db_q;

    // The count "reaches" DEBOUNCE_CYCLES on the edge that would increment past DEBOUNCE_CYCLES-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == db_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_q[i]   <= sync_out[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign filt = db_q;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign filt = sync_out;
`endif

    always_comb begin
        // NOTE: default assigned first so no case path leaves edge_det unassigned (no latch).
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = filt & ~prev_q;
            1:       edge_det = ~filt & prev_q;
            default: edge_det = filt ^ prev_q;
        endcase
    end

    assign clr = (wr_en && address == ADDR_CAP) ? writedata[WIDTH-1:0] : '0;

    // Set is OR-ed in after the clear so a simultaneous edge wins over W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            cap_q  <= '0;
            mask_q <= '0;
        end else begin
            prev_q <= filt;
            cap_q  <= (cap_q & ~clr) | edge_det;
            if (wr_en && address == ADDR_MASK) mask_q <= writedata[WIDTH-1:0];
        end
    end

    assign irq = |(cap_q & mask_q);

    always_comb begin
        readdata = '0;
        case (addr_e'(address))
            ADDR_DATA: readdata[WIDTH-1:0] = filt;
            ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_CAP:  readdata[WIDTH-1:0] = cap_q;
            default:   readdata = '0;
        endcase
    end

endmodule
